// File: rtl/mips_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: serializer state encoding, register offsets relative to
// BASE_ADDR, and the bit positions of the STATUS word.
package mips_uart_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

endpackage

// File: rtl/mips_sync_fifo.sv
// 8-bit synchronous FIFO, DEPTH entries (power of two).
// Ports: clock/reset (async high), push/wdata, pop/rdata (rdata shows the
// head entry combinationally), full, empty, count.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module mips_sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import mips_uart_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clock) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;

endmodule

// File: rtl/mips_uart_tx_mmio.sv
// Memory-mapped UART transmitter for the mips_core data bus.
// Ports: clock, reset (async high); mem_write/mem_read/address/write_data
// from the core; read_data (combinational) and hit back to the core's load
// mux; tx serial line (idle high, registered) and tx_busy.
// sw BASE_ADDR queues write_data[7:0]; lw BASE_ADDR+4 returns
// {count, overflow, busy, empty, full}; sw BASE_ADDR+4 clears overflow.
module mips_uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        tx,
  output logic        tx_busy
);
  import mips_uart_pkg::*;

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            tx_hit, st_hit;
  logic            push, pop, full, empty, ovf;
  logic [7:0]      rdata, shift;
  logic [CW-1:0]   count;
  logic [3:0]      cnt4;
  logic [31:0]     status;
  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bitn;
  logic            baud_last;
  logic            unused_wd;

  assign unused_wd = ^write_data[31:8];

  assign tx_hit = (address == BASE_ADDR + TXDATA_OFS);
  assign st_hit = (address == BASE_ADDR + STATUS_OFS);
  assign hit    = tx_hit || st_hit;

  // Full is the pre-edge value, so a pop on the same edge never frees a slot
  // for this write.
  assign push = mem_write && tx_hit && !full;

  mips_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (write_data[7:0]),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Sticky overflow; a drop and a clear on the same edge keeps it set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              ovf <= 1'b0;
    else if (mem_write && tx_hit && full)   ovf <= 1'b1;
    else if (mem_write && st_hit)           ovf <= 1'b0;
  end

  assign cnt4    = 4'(count);
  assign tx_busy = (state != ST_IDLE);

  always_comb begin
    status                       = '0;
    status[ST_FULL]              = full;
    status[ST_EMPTY]             = empty;
    status[ST_BUSY]              = tx_busy;
    status[ST_OVF]               = ovf;
    status[ST_CNT_LSB +: 4]      = cnt4;
  end

  assign read_data = (mem_read && st_hit) ? status : 32'd0;

  assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));

  // Pop from IDLE, or at the last stop-bit cycle to chain frames gap-free.
  assign pop = !empty && ((state == ST_IDLE) || (state == ST_STOP && baud_last));

  // tx is loaded with the level of the state being entered, so it is a
  // clean register output aligned with the state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      baud  <= '0;
      bitn  <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift <= rdata;
            baud  <= '0;
            state <= ST_START;
            tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud  <= '0;
            bitn  <= '0;
            state <= ST_DATA;
            tx    <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud <= '0;
            if (bitn == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bitn  <= bitn + 1'b1;
              shift <= shift >> 1;
              tx    <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud <= '0;
            if (!empty) begin
              shift <= rdata;
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_uart_tx_mmio.sv
// Bench for mips_uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// Expected line waveforms are built from the frame definition
// (start 0, eight data bits LSB first, stop 1, C cycles each); a line
// monitor decodes frames independently and they are compared with the
// queue of bytes the bus model says were accepted.
module tb_mips_uart_tx_mmio;
  localparam int          C    = 4;
  localparam int          D    = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clock, reset, mem_write, mem_read, hit, tx, tx_busy;
  logic [31:0] address, write_data, read_data;

  int pass_cnt = 0;
  int total    = 0;

  mips_uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .address(address), .write_data(write_data), .read_data(read_data),
    .hit(hit), .tx(tx), .tx_busy(tx_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Line monitor: decodes frames from tx, storing {stop_bit, byte}.
  logic [8:0] rx_mem [256];
  int         rx_wr = 0;
  int         mon_off = 0;
  logic       mon_act = 1'b0;
  logic [7:0] mon_sh = '0;

  always @(negedge clock) begin
    if (reset) begin
      mon_act <= 1'b0;
      mon_off <= 0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act <= 1'b1;
        mon_off <= 1;
      end
    end else begin
      mon_off <= mon_off + 1;
      if (mon_off >= C && mon_off < 9*C && (mon_off % C) == C/2)
        mon_sh <= {tx, mon_sh[7:1]};
      if (mon_off == 9*C + C/2) begin
        rx_mem[rx_wr % 256] <= {tx, mon_sh};
        rx_wr <= rx_wr + 1;
      end
      if (mon_off == 10*C - 1) mon_act <= 1'b0;
    end
  end

  logic [7:0] exp_q [$];
  int         rx_rd = 0;

  task automatic idle_bus();
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    @(negedge clock);
    mem_read = 1'b1;
    address  = BASE + 32'd4;
    #1;
    total++;
    if (read_data !== exp || hit !== 1'b1)
      $display("FAIL %s: status=%h hit=%b, required status=%h hit=1", name, read_data, hit, exp);
    else pass_cnt++;
    mem_read = 1'b0;
  endtask

  task automatic check_rx(input string name);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      total++;
      if (rx_rd >= rx_wr) begin
        $display("FAIL %s: frame missing, required byte %h", name, e);
      end else begin
        if (rx_mem[rx_rd % 256] !== {1'b1, e})
          $display("FAIL %s: decoded {stop,byte}=%h, required %h", name, rx_mem[rx_rd % 256], {1'b1, e});
        else pass_cnt++;
        rx_rd++;
      end
    end
    total++;
    if (rx_rd != rx_wr) $display("FAIL %s_extra: decoded %0d frames, required %0d", name, rx_wr, rx_rd);
    else pass_cnt++;
    rx_rd = rx_wr;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clock);
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) begin
      total++;
      $display("FAIL %s_timeout: tx_busy=%b after %0d cycles, required 0", name, tx_busy, n);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    idle_bus();
    reset = 1'b1;
    #13;
    total++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || read_data !== 32'h0)
      $display("FAIL reset_outputs: tx=%b busy=%b rd=%h, required 1 0 0", tx, tx_busy, read_data);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    read_status("reset_status", 32'h2);
    total++;
    if (tx !== 1'b1 || tx_busy !== 1'b0)
      $display("FAIL reset_line: tx=%b busy=%b, required 1 0", tx, tx_busy);
    else pass_cnt++;
  endtask

  // Back-to-back writes of b from idle; the waveform is compared cycle by
  // cycle against frames built from the byte values.
  task automatic test_frames(input string name, input logic [7:0] b [$]);
    int n, len, bad, busy_n, first_bad;
    logic st, sb, sbz, eb;
    n = b.size();
    len = 10*C*n + 3;
    bad = 0; busy_n = 0; first_bad = -1; st = 1'b1; eb = 1'b0;
    @(negedge clock);
    mem_write = 1'b1; address = BASE; write_data = {24'h0, b[0]};
    for (int t = 0; t <= len; t++) begin
      @(posedge clock);
      #1;
      if (t + 1 < n) write_data = {24'h0, b[t+1]};
      else mem_write = 1'b0;
      @(negedge clock);
      sb = tx; sbz = tx_busy;
      if (t == 0 || t > 10*C*n) begin
        st = 1'b1; eb = 1'b0;
      end else begin
        int c, f, p;
        logic [7:0] cur;
        c = t - 1; f = c / (10*C); p = (c % (10*C)) / C;
        cur = b[f];
        st = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : cur[p-1];
        eb = 1'b1;
      end
      if (sbz === 1'b1) busy_n++;
      if (sb !== st || sbz !== eb) begin
        bad++;
        if (first_bad < 0) first_bad = t;
      end
    end
    total++;
    if (bad != 0) $display("FAIL %s_wave: %0d cycles differ, first at cycle %0d after write edge", name, bad, first_bad);
    else pass_cnt++;
    total++;
    if (busy_n != 10*C*n) $display("FAIL %s_busy: tx_busy high %0d cycles, required %0d", name, busy_n, 10*C*n);
    else pass_cnt++;
    foreach (b[i]) exp_q.push_back(b[i]);
    check_rx(name);
  endtask

  task automatic test_overflow();
    logic [7:0] b [10];
    foreach (b[i]) b[i] = 8'($urandom);
    @(negedge clock);
    mem_write = 1'b1; address = BASE; write_data = {24'h0, b[0]};
    for (int i = 1; i < 10; i++) begin
      @(posedge clock);
      #1;
      write_data = {24'h0, b[i]};
    end
    @(posedge clock);
    #1;
    mem_write = 1'b0;
    read_status("ovf_full", 32'h8D);
    @(negedge clock);
    mem_write = 1'b1; address = BASE + 32'd4; write_data = $urandom;
    @(posedge clock);
    #1;
    mem_write = 1'b0;
    read_status("ovf_clear", 32'h85);
    for (int i = 0; i < 9; i++) exp_q.push_back(b[i]);
    wait_idle("ovf_drain", 1000);
    check_rx("ovf_bytes");
    read_status("ovf_idle", 32'h2);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 6);
      @(negedge clock);
      for (int i = 0; i < n; i++) begin
        logic [7:0] v;
        v = 8'($urandom);
        exp_q.push_back(v);
        mem_write = 1'b1; address = BASE; write_data = {$urandom, v} >> 0;
        write_data[7:0] = v;
        @(posedge clock);
        #1;
      end
      mem_write = 1'b0;
      repeat ($urandom_range(0, 60)) @(negedge clock);
      wait_idle("rand_drain", 600);
      check_rx("rand_bytes");
      read_status("rand_idle", 32'h2);
    end
  endtask

  task automatic test_mid_reset();
    int snap, ones;
    @(negedge clock);
    mem_write = 1'b1; address = BASE; write_data = 32'h0;
    @(posedge clock);
    #1;
    mem_write = 1'b0;
    repeat (1 + C + 6) @(negedge clock);
    total++;
    if (tx !== 1'b0 || tx_busy !== 1'b1)
      $display("FAIL midrst_pre: tx=%b busy=%b, required 0 1", tx, tx_busy);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (tx !== 1'b1 || tx_busy !== 1'b0)
      $display("FAIL midrst_async: tx=%b busy=%b, required 1 0", tx, tx_busy);
    else pass_cnt++;
    @(negedge clock);
    #2 reset = 1'b0;
    snap = rx_wr;
    read_status("midrst_status", 32'h2);
    ones = 0;
    repeat (60) begin
      @(negedge clock);
      if (tx === 1'b1) ones++;
    end
    total++;
    if (ones != 60 || rx_wr != snap)
      $display("FAIL midrst_quiet: tx high %0d/60 cycles, frames %0d, required 60 and %0d", ones, rx_wr, snap);
    else pass_cnt++;
    rx_rd = rx_wr;
  endtask

  task automatic test_decode();
    logic [31:0] addrs [2];
    addrs[0] = BASE + 32'd8;
    addrs[1] = 32'h0000_0010;
    foreach (addrs[i]) begin
      int ones;
      @(negedge clock);
      mem_write = 1'b1; mem_read = 1'b1; address = addrs[i]; write_data = $urandom;
      #1;
      total++;
      if (hit !== 1'b0 || read_data !== 32'h0)
        $display("FAIL decode_miss: addr=%h hit=%b rd=%h, required 0 0", addrs[i], hit, read_data);
      else pass_cnt++;
      @(posedge clock);
      #1;
      idle_bus();
      ones = 0;
      repeat (10) begin
        @(negedge clock);
        if (tx === 1'b1) ones++;
      end
      total++;
      if (ones != 10) $display("FAIL decode_tx: tx high %0d/10 cycles, required 10", ones);
      else pass_cnt++;
      read_status("decode_status", 32'h2);
    end
    @(negedge clock);
    mem_read = 1'b1; address = BASE;
    #1;
    total++;
    if (hit !== 1'b1 || read_data !== 32'h0)
      $display("FAIL decode_txdata_read: hit=%b rd=%h, required 1 0", hit, read_data);
    else pass_cnt++;
    idle_bus();
  endtask

  initial begin
    logic [7:0] q [$];
    test_reset();
    q = {8'h55};
    test_frames("f55", q);
    test_overflow();
    q = {8'hA5, 8'h3C};
    test_frames("pair", q);
    q = {8'($urandom), 8'($urandom), 8'($urandom)};
    test_frames("rand3", q);
    test_random();
    test_mid_reset();
    test_decode();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
